// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous-SRAM access controller for the z80computer bus.
// The CPU side raises i_cs with address/data/direction held stable and waits
// for o_ack (four-phase handshake). i_cs is resynchronised into this 100 MHz
// domain, and the controller then runs the SRAM through setup, strobe (access)
// and hold phases whose lengths are set by parameters in 10 ns steps.
// Every output is a flop, so the pads never see combinational glitches.
module sram_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic              i_clk100mhz,
  input  logic              resetn,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_dat,
  output logic [7:0]        o_dat,
  output logic              o_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [7:0]        o_sram_dout,
  output logic              o_sram_doe,
  input  logic [7:0]        i_sram_din,
  output logic              o_sram_cs_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
);

  // One shared phase counter is enough because the phases never overlap;
  // it only has to reach the longest phase length minus one.
  localparam int MAX_CYC_SA = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_CYC    = (MAX_CYC_SA > HOLD_CYC) ? MAX_CYC_SA : HOLD_CYC;
  localparam int CNT_W      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  // A zero-length phase would collapse the SRAM timing, so refuse to build.
  if (SETUP_CYC < 1 || ACCESS_CYC < 1 || HOLD_CYC < 1) begin : gBadTiming
    $error("sram_ctrl: SETUP_CYC, ACCESS_CYC and HOLD_CYC must all be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             isWrite_q;
  logic             csMeta_q;
  logic             csSync_q;

  // Two-flop synchronizer for the request coming from the 25 MHz CPU domain.
  always_ff @(posedge i_clk100mhz) begin
    if (!resetn) begin
      csMeta_q <= 1'b0;
      csSync_q <= 1'b0;
    end else begin
      csMeta_q <= i_cs;
      csSync_q <= csMeta_q;
    end
  end

  // Access sequencer: walks setup/access/hold and drives every SRAM pin and the ack.
  always_ff @(posedge i_clk100mhz) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      isWrite_q   <= 1'b0;
      o_ack       <= 1'b0;
      o_dat       <= 8'h00;
      o_sram_addr <= '0;
      o_sram_dout <= 8'h00;
      o_sram_doe  <= 1'b0;
      o_sram_cs_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (csSync_q) begin
            state_q     <= SETUP;
            cnt_q       <= '0;
            isWrite_q   <= i_we;
            o_sram_addr <= i_addr;
            o_sram_cs_n <= 1'b0;
            if (i_we) begin
              o_sram_dout <= i_dat;
              o_sram_doe  <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
            if (isWrite_q) begin
              o_sram_we_n <= 1'b0;
            end else begin
              o_sram_oe_n <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ACCESS: begin
          if (cnt_q == ACCESS_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            if (isWrite_q) begin
              o_sram_we_n <= 1'b1;
            end else begin
              o_dat       <= i_sram_din;
              o_sram_oe_n <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= DONE;
            cnt_q       <= '0;
            o_sram_cs_n <= 1'b1;
            o_sram_doe  <= 1'b0;
            o_ack       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (!csSync_q) begin
            state_q <= IDLE;
            o_ack   <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with a behavioural SRAM and a
// scoreboard. dut0 uses the default timing, dut1 uses 2/7/3 timing.
module tb_sram_ctrl;

  localparam int AW = 18;

  typedef struct {
    int             dutIdx;
    logic           isWrite;
    logic [AW-1:0]  addr;
    logic [7:0]     data;
    int             ackCycle;
  } txn_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cs [2];
  logic          we [2];
  logic [AW-1:0] addrIn [2];
  logic [7:0]    datIn [2];
  logic [7:0]    datOut [2];
  logic          ackO [2];
  logic [AW-1:0] sramAddr [2];
  logic [7:0]    sramDout [2];
  logic          sramDoe [2];
  logic [7:0]    sramDin [2];
  logic          sramCsN [2];
  logic          sramOeN [2];
  logic          sramWeN [2];

  logic [7:0] mem [0:(1<<AW)-1];
  txn_t       sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  sram_ctrl dut0 (
    .i_clk100mhz (clk),
    .resetn      (resetn),
    .i_cs        (cs[0]),
    .i_we        (we[0]),
    .i_addr      (addrIn[0]),
    .i_dat       (datIn[0]),
    .o_dat       (datOut[0]),
    .o_ack       (ackO[0]),
    .o_sram_addr (sramAddr[0]),
    .o_sram_dout (sramDout[0]),
    .o_sram_doe  (sramDoe[0]),
    .i_sram_din  (sramDin[0]),
    .o_sram_cs_n (sramCsN[0]),
    .o_sram_oe_n (sramOeN[0]),
    .o_sram_we_n (sramWeN[0])
  );

  sram_ctrl #(.ADDR_W(AW), .SETUP_CYC(2), .ACCESS_CYC(7), .HOLD_CYC(3)) dut1 (
    .i_clk100mhz (clk),
    .resetn      (resetn),
    .i_cs        (cs[1]),
    .i_we        (we[1]),
    .i_addr      (addrIn[1]),
    .i_dat       (datIn[1]),
    .o_dat       (datOut[1]),
    .o_ack       (ackO[1]),
    .o_sram_addr (sramAddr[1]),
    .o_sram_dout (sramDout[1]),
    .o_sram_doe  (sramDoe[1]),
    .i_sram_din  (sramDin[1]),
    .o_sram_cs_n (sramCsN[1]),
    .o_sram_oe_n (sramOeN[1]),
    .o_sram_we_n (sramWeN[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Request sampled at edge cyc+1, SETUP two edges later, then S+A+H phase clocks.
  function automatic int latency(input int g);
    return (g == 0) ? (1 + 2 + 1 + 4 + 1) : (1 + 2 + 2 + 7 + 3);
  endfunction

  task automatic applyStimulus(input int g, input logic isWrite, input logic [AW-1:0] a, input logic [7:0] d);
    txn_t t;
    t.dutIdx   = g;
    t.isWrite  = isWrite;
    t.addr     = a;
    t.data     = d;
    t.ackCycle = cyc + latency(g);
    sb.push_back(t);
    we[g]     = isWrite;
    addrIn[g] = a;
    datIn[g]  = isWrite ? d : 8'h00;
    cs[g]     = 1'b1;
  endtask

  task automatic waitAck(input int g, input logic level, input int budget);
    int n = 0;
    while (ackO[g] !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("ack%0d level %0b", g, level), {31'd0, ackO[g]}, {31'd0, level});
  endtask

  // Per-DUT SRAM model and protocol monitor, sampled on the falling edge.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int S = (g == 0) ? 1 : 2;
    localparam int A = (g == 0) ? 4 : 7;
    localparam int H = (g == 0) ? 1 : 3;

    int   ph = 0;
    int   phCnt = 0;
    int   accesses = 0;
    logic prevWe = 1'b1;
    logic prevAck = 1'b0;
    logic strobeLow;

    assign strobeLow  = !(sramOeN[g] && sramWeN[g]);
    assign sramDin[g] = (!sramCsN[g] && !sramOeN[g]) ? mem[sramAddr[g]] : 8'hEE;

    always @(negedge clk) begin
      checkOutput($sformatf("dut%0d oe_n|we_n", g), {31'd0, sramOeN[g] | sramWeN[g]}, 32'd1);
      if (sramDoe[g]) begin
        checkOutput($sformatf("dut%0d cs_n while doe", g), {31'd0, sramCsN[g]}, 32'd0);
        checkOutput($sformatf("dut%0d oe_n while doe", g), {31'd0, sramOeN[g]}, 32'd1);
      end

      if (!prevWe && sramWeN[g] && !sramCsN[g] && sramDoe[g]) begin
        mem[sramAddr[g]] <= sramDout[g];
      end
      prevWe <= sramWeN[g];

      if (sramCsN[g]) begin
        if (ph == 3) checkOutput($sformatf("dut%0d hold clocks", g), phCnt, H);
        ph    <= 0;
        phCnt <= 0;
      end else if (ph == 0 || ph == 1) begin
        if (!strobeLow) begin
          ph    <= 1;
          phCnt <= phCnt + 1;
          if (sb.size() > 0 && sb[0].dutIdx == g)
            checkOutput($sformatf("dut%0d doe in setup", g), {31'd0, sramDoe[g]}, {31'd0, sb[0].isWrite});
        end else begin
          checkOutput($sformatf("dut%0d setup clocks", g), phCnt, S);
          accesses <= accesses + 1;
          if (sb.size() > 0 && sb[0].dutIdx == g) begin
            checkOutput($sformatf("dut%0d addr", g), {14'd0, sramAddr[g]}, {14'd0, sb[0].addr});
            checkOutput($sformatf("dut%0d we_n at strobe", g), {31'd0, sramWeN[g]}, {31'd0, !sb[0].isWrite});
            checkOutput($sformatf("dut%0d doe at strobe", g), {31'd0, sramDoe[g]}, {31'd0, sb[0].isWrite});
            if (sb[0].isWrite)
              checkOutput($sformatf("dut%0d dout", g), {24'd0, sramDout[g]}, {24'd0, sb[0].data});
          end
          ph    <= 2;
          phCnt <= 1;
        end
      end else if (ph == 2) begin
        if (strobeLow) begin
          phCnt <= phCnt + 1;
        end else begin
          checkOutput($sformatf("dut%0d strobe clocks", g), phCnt, A);
          ph    <= 3;
          phCnt <= 1;
        end
      end else begin
        phCnt <= phCnt + 1;
      end

      if (ackO[g] && !prevAck) begin
        if (sb.size() == 0 || sb[0].dutIdx != g) begin
          checkOutput($sformatf("dut%0d unexpected ack", g), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("dut%0d ack cycle", g), cyc, sb[0].ackCycle);
          if (sb[0].isWrite)
            checkOutput($sformatf("dut%0d sram byte", g), {24'd0, mem[sb[0].addr]}, {24'd0, sb[0].data});
          else
            checkOutput($sformatf("dut%0d read data", g), {24'd0, datOut[g]}, {24'd0, sb[0].data});
          void'(sb.pop_front());
        end
      end
      prevAck <= ackO[g];
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      cs[i]     = 1'b0;
      we[i]     = 1'b0;
      addrIn[i] = '0;
      datIn[i]  = 8'h00;
    end
    mem[18'h01234] = 8'hA5;
    mem[18'h00010] = 8'h3C;

    // reset held three clocks with a read request already pending
    resetn    = 1'b0;
    cs[0]     = 1'b1;
    addrIn[0] = 18'h01234;
    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", {31'd0, sramCsN[0]}, 32'd1);
    checkOutput("reset oe_n", {31'd0, sramOeN[0]}, 32'd1);
    checkOutput("reset we_n", {31'd0, sramWeN[0]}, 32'd1);
    checkOutput("reset doe", {31'd0, sramDoe[0]}, 32'd0);
    checkOutput("reset ack", {31'd0, ackO[0]}, 32'd0);
    checkOutput("reset dat", {24'd0, datOut[0]}, 32'd0);
    checkOutput("reset addr", {14'd0, sramAddr[0]}, 32'd0);
    checkOutput("reset dout", {24'd0, sramDout[0]}, 32'd0);

    resetn = 1'b1;
    applyStimulus(0, 1'b0, 18'h01234, 8'hA5);
    repeat (2) @(negedge clk);
    checkOutput("idle 2 clocks after reset", {31'd0, sramCsN[0]}, 32'd1);
    @(negedge clk);
    checkOutput("access after reset", {31'd0, sramCsN[0]}, 32'd0);
    waitAck(0, 1'b1, 40);

    // request held long after ack: exactly one access, ack stays up
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("ack held", {31'd0, ackO[0]}, 32'd1);
    end
    checkOutput("single access", mon[0].accesses, 32'd1);
    cs[0] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ack 2 clocks after drop", {31'd0, ackO[0]}, 32'd1);
    @(negedge clk);
    checkOutput("ack 3 clocks after drop", {31'd0, ackO[0]}, 32'd0);

    // immediate re-request: top-of-memory write
    applyStimulus(0, 1'b1, 18'h3FFFF, 8'h5A);
    waitAck(0, 1'b1, 40);
    cs[0] = 1'b0;
    waitAck(0, 1'b0, 10);
    checkOutput("second access", mon[0].accesses, 32'd2);

    applyStimulus(0, 1'b0, 18'h3FFFF, 8'h5A);
    waitAck(0, 1'b1, 40);
    cs[0] = 1'b0;
    waitAck(0, 1'b0, 10);

    // request withdrawn early: access completes, ack is a single-clock pulse
    applyStimulus(0, 1'b0, 18'h00010, 8'h3C);
    repeat (2) @(negedge clk);
    cs[0] = 1'b0;
    waitAck(0, 1'b1, 40);
    @(negedge clk);
    checkOutput("ack pulse", {31'd0, ackO[0]}, 32'd0);
    repeat (5) @(negedge clk);

    // reset during the strobe of a write
    we[0]     = 1'b1;
    addrIn[0] = 18'h00100;
    datIn[0]  = 8'h77;
    cs[0]     = 1'b1;
    n = 0;
    while (sramWeN[0] && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("write strobe reached", {31'd0, sramWeN[0]}, 32'd0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("abort we_n", {31'd0, sramWeN[0]}, 32'd1);
    checkOutput("abort cs_n", {31'd0, sramCsN[0]}, 32'd1);
    checkOutput("abort doe", {31'd0, sramDoe[0]}, 32'd0);
    checkOutput("abort ack", {31'd0, ackO[0]}, 32'd0);
    cs[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("no ack after abort", {31'd0, ackO[0]}, 32'd0);
    checkOutput("idle after abort", {31'd0, sramCsN[0]}, 32'd1);

    applyStimulus(0, 1'b0, 18'h01234, 8'hA5);
    waitAck(0, 1'b1, 40);
    cs[0] = 1'b0;
    waitAck(0, 1'b0, 10);

    // slow timing instance
    applyStimulus(1, 1'b1, 18'h00ABC, 8'hC3);
    waitAck(1, 1'b1, 60);
    cs[1] = 1'b0;
    waitAck(1, 1'b0, 10);
    applyStimulus(1, 1'b0, 18'h00ABC, 8'hC3);
    waitAck(1, 1'b1, 60);
    cs[1] = 1'b0;
    waitAck(1, 1'b0, 10);
    checkOutput("dut1 accesses", mon[1].accesses, 32'd2);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
